// File: rtl/miner_pkg.sv
// Shared definitions for the multi-core miner register block: address map,
// control bit positions, status encoding and the nonce partition helper.
package miner_pkg;

    localparam logic [4:0] ADDR_STATUS = 5'd0;
    localparam logic [4:0] ADDR_CTRL   = 5'd1;
    localparam logic [4:0] ADDR_TGT_LO = 5'd2;
    localparam logic [4:0] ADDR_TGT_HI = 5'd9;
    localparam logic [4:0] ADDR_NONCE  = 5'd10;
    localparam logic [4:0] ADDR_MSG_LO = 5'd11;
    localparam logic [4:0] ADDR_MSG_HI = 5'd29;
    localparam logic [4:0] ADDR_WINNER = 5'd30;
    localparam logic [4:0] ADDR_NCORES = 5'd31;

    localparam int TGT_WORDS = 8;
    localparam int MSG_WORDS = 19;

    localparam int CTRL_LOAD_TGT = 0;
    localparam int CTRL_START    = 1;
    localparam int CTRL_ABORT    = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUNNING   = 3'd1,
        FOUND     = 3'd3,
        EXHAUSTED = 3'd4
    } status_e;

    // First nonce of core idx when the 32-bit space is split into ncores equal slices.
    function automatic logic [31:0] partition_base(input int idx, input int ncores);
        int log2n;
        log2n = $clog2(ncores);
        if (log2n == 0) begin
            return 32'd0;
        end
        return 32'(idx) << (32 - log2n);
    endfunction

endpackage

// File: rtl/miner_found_arbiter.sv
// Picks the lowest-index core reporting a hit this cycle and forwards its nonce.
module miner_found_arbiter
    import miner_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int CORE_IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic [NUM_CORES-1:0]    found_i,
    input  logic [NUM_CORES*32-1:0] nonce_i,
    output logic                    any_o,
    output logic [CORE_IDX_W-1:0]   idx_o,
    output logic [31:0]             nonce_o
);

    logic [31:0] nonce_words [NUM_CORES];

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_split
            assign nonce_words[gi] = nonce_i[gi*32 +: 32];
        end
    endgenerate

    // Scanning downward lets the lowest set index overwrite higher ones.
    always_comb begin
        any_o   = |found_i;
        idx_o   = '0;
        nonce_o = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (found_i[i]) begin
                idx_o   = CORE_IDX_W'(i);
                nonce_o = nonce_words[i];
            end
        end
    end

endmodule

// File: rtl/miner_csr_multi.sv
// Avalon-MM register front end for NUM_CORES SHA-256 miner cores: staging and
// shadow registers, nonce partitioning, run sequencing and winner capture.
module miner_csr_multi
    import miner_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int CORE_IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [4:0]              slaveAddr,
    input  logic [31:0]             slaveWriteData,
    input  logic                    slaveWrite,
    input  logic                    slaveRead,
    input  logic                    slaveChipSelect,
    output logic [31:0]             slaveReadData,
    output logic [255:0]            target,
    output logic [607:0]            message,
    output logic [NUM_CORES-1:0]    core_start,
    output logic                    core_abort,
    output logic [NUM_CORES*32-1:0] core_start_nonce,
    input  logic [NUM_CORES-1:0]    core_found,
    input  logic [NUM_CORES*32-1:0] core_nonce,
    input  logic [NUM_CORES-1:0]    core_done,
    output logic                    irq
);

    logic wr_en;
    logic rd_en;
    logic ctrl_wr;
    logic do_abort;
    logic do_start;
    logic do_load_tgt;
    logic do_load_msg;

    assign wr_en       = slaveChipSelect & slaveWrite;
    assign rd_en       = slaveChipSelect & slaveRead;
    assign ctrl_wr     = wr_en & (slaveAddr == ADDR_CTRL);
    assign do_abort    = ctrl_wr & slaveWriteData[CTRL_ABORT];
    assign do_start    = ctrl_wr & slaveWriteData[CTRL_START] & ~slaveWriteData[CTRL_ABORT];
    assign do_load_tgt = ctrl_wr & slaveWriteData[CTRL_LOAD_TGT];
    assign do_load_msg = ctrl_wr & slaveWriteData[CTRL_START];

    // Staging words: bus-visible, writable at any time.
    logic [31:0]              tgt_words [TGT_WORDS];
    logic [31:0]              msg_words [MSG_WORDS];
    logic [TGT_WORDS*32-1:0]  tgt_stage;
    logic [MSG_WORDS*32-1:0]  msg_stage;

    generate
        for (genvar gi = 0; gi < TGT_WORDS; gi++) begin : g_tgt
            localparam logic [4:0] WORD_ADDR = 5'(ADDR_TGT_LO + gi);
            logic [31:0] word_q;
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    word_q <= '0;
                end else if (wr_en && slaveAddr == WORD_ADDR) begin
                    word_q <= slaveWriteData;
                end
            end
            assign tgt_words[gi]            = word_q;
            assign tgt_stage[gi*32 +: 32]   = word_q;
        end

        for (genvar gi = 0; gi < MSG_WORDS; gi++) begin : g_msg
            localparam logic [4:0] WORD_ADDR = 5'(ADDR_MSG_LO + gi);
            logic [31:0] word_q;
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    word_q <= '0;
                end else if (wr_en && slaveAddr == WORD_ADDR) begin
                    word_q <= slaveWriteData;
                end
            end
            assign msg_words[gi]            = word_q;
            assign msg_stage[gi*32 +: 32]   = word_q;
        end

        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_part
            assign core_start_nonce[gi*32 +: 32] = partition_base(gi, NUM_CORES);
        end
    endgenerate

    // Shadows feed the cores so staging can be rewritten while a run is active.
    logic [255:0] target_q;
    logic [607:0] message_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            target_q  <= '0;
            message_q <= '0;
        end else begin
            if (do_load_tgt) begin
                target_q <= tgt_stage;
            end
            if (do_load_msg) begin
                message_q <= msg_stage;
            end
        end
    end

    assign target  = target_q;
    assign message = message_q;

    logic                  found_any;
    logic [CORE_IDX_W-1:0] found_idx;
    logic [31:0]           found_nonce;

    miner_found_arbiter #(
        .NUM_CORES  (NUM_CORES),
        .CORE_IDX_W (CORE_IDX_W)
    ) u_arbiter (
        .found_i (core_found),
        .nonce_i (core_nonce),
        .any_o   (found_any),
        .idx_o   (found_idx),
        .nonce_o (found_nonce)
    );

    status_e               state_q;
    logic                  start_q;
    logic                  abort_q;
    logic                  restart_q;
    logic [31:0]           result_nonce_q;
    logic [CORE_IDX_W-1:0] winner_q;

    // Hits and done levels are ignored while a start pulse is pending or on the
    // wire, since core_done is only cleared once the cores see core_start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            start_q        <= 1'b0;
            abort_q        <= 1'b0;
            restart_q      <= 1'b0;
            result_nonce_q <= '0;
            winner_q       <= '0;
        end else begin
            start_q <= 1'b0;
            abort_q <= 1'b0;
            if (do_abort) begin
                state_q   <= IDLE;
                abort_q   <= 1'b1;
                restart_q <= 1'b0;
            end else if (do_start) begin
                if (state_q == RUNNING) begin
                    abort_q   <= 1'b1;
                    restart_q <= 1'b1;
                end else begin
                    state_q <= RUNNING;
                    start_q <= 1'b1;
                end
                result_nonce_q <= '0;
                winner_q       <= '0;
            end else if (restart_q) begin
                restart_q <= 1'b0;
                start_q   <= 1'b1;
            end else if (state_q == RUNNING && !start_q) begin
                if (found_any) begin
                    state_q        <= FOUND;
                    result_nonce_q <= found_nonce;
                    winner_q       <= found_idx;
                    abort_q        <= 1'b1;
                end else if (&core_done) begin
                    state_q <= EXHAUSTED;
                end
            end
        end
    end

    assign core_start = {NUM_CORES{start_q}};
    assign core_abort = abort_q;
    assign irq        = (state_q == FOUND) || (state_q == EXHAUSTED);

    logic [2:0]  tgt_idx;
    logic [4:0]  msg_idx;
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    assign tgt_idx = 3'(slaveAddr - ADDR_TGT_LO);
    assign msg_idx = slaveAddr - ADDR_MSG_LO;

    always_comb begin
        rdata_d = '0;
        if (slaveAddr == ADDR_STATUS) begin
            rdata_d = {29'd0, state_q};
        end else if (slaveAddr == ADDR_NONCE) begin
            rdata_d = result_nonce_q;
        end else if (slaveAddr == ADDR_WINNER) begin
            rdata_d = 32'(winner_q);
        end else if (slaveAddr == ADDR_NCORES) begin
            rdata_d = 32'(NUM_CORES);
        end else if (slaveAddr >= ADDR_TGT_LO && slaveAddr <= ADDR_TGT_HI) begin
            rdata_d = tgt_words[tgt_idx];
        end else if (slaveAddr >= ADDR_MSG_LO && slaveAddr <= ADDR_MSG_HI) begin
            rdata_d = msg_words[msg_idx];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= rdata_d;
        end
    end

    assign slaveReadData = rdata_q;

endmodule

// File: tb/tb_miner_csr_multi.sv
// Randomised and directed bench for miner_csr_multi against a cycle-scheduled
// behavioural model of the register map and run sequencing.
module tb_miner_csr_multi;

    localparam int NC = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           n_rst = 1'b0;
    logic [4:0]     slaveAddr = '0;
    logic [31:0]    slaveWriteData = '0;
    logic           slaveWrite = 1'b0;
    logic           slaveRead = 1'b0;
    logic           slaveChipSelect = 1'b0;
    logic [31:0]    slaveReadData;
    logic [255:0]   target;
    logic [607:0]   message;
    logic [NC-1:0]  core_start;
    logic           core_abort;
    logic [NC*32-1:0] core_start_nonce;
    logic [NC-1:0]  core_found = '0;
    logic [NC*32-1:0] core_nonce = '0;
    logic [NC-1:0]  core_done = '0;
    logic           irq;

    always #5 clk = ~clk;

    miner_csr_multi #(.NUM_CORES(NC), .CORE_IDX_W(IW)) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .slaveAddr        (slaveAddr),
        .slaveWriteData   (slaveWriteData),
        .slaveWrite       (slaveWrite),
        .slaveRead        (slaveRead),
        .slaveChipSelect  (slaveChipSelect),
        .slaveReadData    (slaveReadData),
        .target           (target),
        .message          (message),
        .core_start       (core_start),
        .core_abort       (core_abort),
        .core_start_nonce (core_start_nonce),
        .core_found       (core_found),
        .core_nonce       (core_nonce),
        .core_done        (core_done),
        .irq              (irq)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [607:0] act, input logic [607:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Status codes: 0 idle, 1 running, 3 found, 4 exhausted. Pulses are kept
    // as the cycle number in which they must be visible.
    int          cyc = 0;
    int          m_status = 0;
    logic [31:0] m_nonce = '0;
    int          m_winner = 0;
    logic [31:0] m_tgt_stage [8];
    logic [31:0] m_msg_stage [19];
    logic [255:0] m_target = '0;
    logic [607:0] m_message = '0;
    logic [31:0] m_rdata = '0;
    int          start_cyc = -100;
    int          abort_cyc = -100;

    function automatic logic [31:0] model_read(input int a);
        if (a == 0) return 32'(m_status);
        if (a >= 2 && a <= 9) return m_tgt_stage[a-2];
        if (a == 10) return m_nonce;
        if (a >= 11 && a <= 29) return m_msg_stage[a-11];
        if (a == 30) return 32'(m_winner);
        if (a == 31) return 32'(NC);
        return 32'd0;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        int a;
        logic [31:0] d;
        bit ctrl_taken;
        if (!n_rst) begin
            m_status = 0; m_nonce = '0; m_winner = 0;
            m_target = '0; m_message = '0; m_rdata = '0;
            start_cyc = -100; abort_cyc = -100;
            for (int i = 0; i < 8; i++) m_tgt_stage[i] = '0;
            for (int i = 0; i < 19; i++) m_msg_stage[i] = '0;
        end else begin
            cyc++;
            ctrl_taken = 1'b0;
            if (slaveChipSelect && slaveRead) m_rdata = model_read(int'(slaveAddr));
            if (slaveChipSelect && slaveWrite) begin
                a = int'(slaveAddr);
                d = slaveWriteData;
                if (a >= 2 && a <= 9) m_tgt_stage[a-2] = d;
                else if (a >= 11 && a <= 29) m_msg_stage[a-11] = d;
                else if (a == 1) begin
                    if (d[0]) for (int i = 0; i < 8; i++) m_target[i*32 +: 32] = m_tgt_stage[i];
                    if (d[1]) for (int i = 0; i < 19; i++) m_message[i*32 +: 32] = m_msg_stage[i];
                    if (d[2]) begin
                        ctrl_taken = 1'b1;
                        m_status = 0;
                        abort_cyc = cyc;
                        if (start_cyc >= cyc) start_cyc = -100;
                    end else if (d[1]) begin
                        ctrl_taken = 1'b1;
                        if (m_status == 1) begin
                            abort_cyc = cyc;
                            start_cyc = cyc + 1;
                        end else begin
                            m_status = 1;
                            start_cyc = cyc;
                        end
                        m_nonce = '0;
                        m_winner = 0;
                    end
                end
            end
            // Cores only report meaningfully once they have seen their start pulse.
            if (!ctrl_taken && m_status == 1 && cyc >= start_cyc + 2) begin
                if (core_found != '0) begin
                    for (int i = 0; i < NC; i++) begin
                        if (core_found[i]) begin
                            m_winner = i;
                            m_nonce = 32'(core_nonce >> (i * 32));
                            break;
                        end
                    end
                    m_status = 3;
                    abort_cyc = cyc;
                end else if (core_done == '1) begin
                    m_status = 4;
                end
            end
        end
    end

    // One compare process: every cycle out of reset, all outputs against the model.
    always @(negedge clk) begin
        if (chk_en && n_rst) begin
            chk("core_start", 608'(core_start), (cyc == start_cyc) ? 608'({NC{1'b1}}) : 608'(0));
            chk("core_abort", 608'(core_abort), 608'(cyc == abort_cyc));
            chk("irq", 608'(irq), 608'(m_status == 3 || m_status == 4));
            chk("target", 608'(target), 608'(m_target));
            chk("message", message, m_message);
            chk("readdata", 608'(slaveReadData), 608'(m_rdata));
            for (int i = 0; i < NC; i++)
                chk("start_nonce", 608'(32'(core_start_nonce >> (i * 32))),
                    608'(32'(longint'(i) * (64'h1_0000_0000 / NC))));
        end
    end

    // ---------------- stimulus ----------------
    // Acts as the cores for core_done: the level drops once core_start is seen.
    task automatic tick();
        @(negedge clk);
        if (core_start != '0) core_done = '0;
    endtask

    task automatic bus_write(input int a, input logic [31:0] d);
        slaveAddr = 5'(a); slaveWriteData = d; slaveChipSelect = 1'b1; slaveWrite = 1'b1;
        tick();
        slaveChipSelect = 1'b0; slaveWrite = 1'b0;
    endtask

    task automatic bus_read(input int a, output logic [31:0] d);
        slaveAddr = 5'(a); slaveChipSelect = 1'b1; slaveRead = 1'b1;
        tick();
        slaveChipSelect = 1'b0; slaveRead = 1'b0;
        d = slaveReadData;
    endtask

    task automatic read_expect(input string name, input int a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(name, 608'(d), 608'(exp));
    endtask

    task automatic pulse_found(input logic [NC-1:0] mask, input logic [NC*32-1:0] nonces);
        core_found = mask; core_nonce = nonces;
        tick();
        core_found = '0;
    endtask

    int ctrl_tab [8] = '{1, 2, 2, 2, 4, 3, 6, 0};
    logic [31:0] exp_nonce [4] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};

    initial begin
        logic [31:0] d;
        int r;
        for (int i = 0; i < 8; i++) m_tgt_stage[i] = '0;
        for (int i = 0; i < 19; i++) m_msg_stage[i] = '0;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        chk_en = 1'b1;

        // 1: reset state
        chk("rst_irq", 608'(irq), 608'(0));
        chk("rst_start", 608'(core_start), 608'(0));
        chk("rst_abort", 608'(core_abort), 608'(0));
        chk("rst_rdata", 608'(slaveReadData), 608'(0));
        read_expect("ncores", 31, 32'd4);
        read_expect("rst_status", 0, 32'd0);

        // 2: target staging and shadow
        bus_write(9, 32'h1000_0000);
        for (int a = 8; a >= 2; a--) bus_write(a, 32'h0);
        bus_write(1, 32'h1);
        chk("target_load", 608'(target), 608'({32'h1000_0000, 224'd0}));
        bus_write(9, 32'hFFFF_FFFF);
        tick();
        chk("target_held", 608'(target), 608'({32'h1000_0000, 224'd0}));
        read_expect("tgt9_stage", 9, 32'hFFFF_FFFF);

        // 3: message load and start
        for (int i = 0; i < 19; i++) bus_write(11 + i, 32'hA000_0000 + 32'(i));
        bus_write(1, 32'h2);
        chk("start_pulse", 608'(core_start), 608'(4'b1111));
        chk("msg_lo", 608'(message[31:0]), 608'(32'hA000_0000));
        chk("msg_hi", 608'(message[607:576]), 608'(32'hA000_0012));
        for (int i = 0; i < NC; i++)
            chk("nonce_lit", 608'(32'(core_start_nonce >> (i * 32))), 608'(exp_nonce[i]));
        tick();
        chk("start_once", 608'(core_start), 608'(0));
        read_expect("status_run", 0, 32'd1);

        // 4: found capture, lowest index wins
        tick();
        pulse_found(4'b0110, {32'h0, 32'h8000_0011, 32'h4000_002A, 32'h0});
        chk("found_abort", 608'(core_abort), 608'(1));
        tick();
        chk("abort_once", 608'(core_abort), 608'(0));
        read_expect("status_found", 0, 32'd3);
        read_expect("result_nonce", 10, 32'h4000_002A);
        read_expect("winner", 30, 32'd1);
        chk("found_irq", 608'(irq), 608'(1));
        chk("model_nonce", 608'(m_nonce), 608'(32'h4000_002A));
        pulse_found(4'b0001, {96'h0, 32'h0000_0123});
        read_expect("nonce_kept", 10, 32'h4000_002A);
        read_expect("winner_kept", 30, 32'd1);

        // 5: exhaustion, then restart from EXHAUSTED
        bus_write(1, 32'h2);
        repeat (2) tick();
        core_done = '1;
        repeat (2) tick();
        read_expect("status_exh", 0, 32'd4);
        chk("exh_irq", 608'(irq), 608'(1));
        bus_write(1, 32'h2);
        tick();
        read_expect("status_rerun", 0, 32'd1);
        read_expect("nonce_clr", 10, 32'd0);
        read_expect("winner_clr", 30, 32'd0);

        // restart while running: abort first, start one cycle later
        bus_write(1, 32'h2);
        chk("restart_abort", 608'(core_abort), 608'(1));
        chk("restart_nostart", 608'(core_start), 608'(0));
        tick();
        chk("restart_start", 608'(core_start), 608'(4'b1111));

        // 6: abort beats start
        tick();
        bus_write(1, 32'h6);
        chk("abort_pulse", 608'(core_abort), 608'(1));
        chk("abort_nostart", 608'(core_start), 608'(0));
        tick();
        chk("abort_nostart2", 608'(core_start), 608'(0));
        read_expect("status_idle", 0, 32'd0);

        // asynchronous reset mid-run
        bus_write(1, 32'h2);
        repeat (2) tick();
        read_expect("pre_rst", 31, 32'd4);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_rdata", 608'(slaveReadData), 608'(0));
        chk("arst_target", 608'(target), 608'(0));
        chk("arst_message", message, 608'(0));
        chk("arst_start", 608'(core_start), 608'(0));
        chk("arst_abort", 608'(core_abort), 608'(0));
        chk("arst_irq", 608'(irq), 608'(0));
        tick();
        n_rst = 1'b1;
        core_done = '0;
        read_expect("post_rst", 0, 32'd0);

        // randomised traffic, checked every cycle by the compare process
        for (int it = 0; it < 800; it++) begin
            r = $urandom_range(0, 99);
            if (r < 25) begin
                bus_write(($urandom_range(0, 1) != 0) ? $urandom_range(2, 9) : $urandom_range(11, 29), $urandom());
            end else if (r < 40) begin
                bus_write(1, 32'(ctrl_tab[$urandom_range(0, 7)]));
            end else if (r < 60) begin
                bus_read($urandom_range(0, 31), d);
            end else if (r < 75) begin
                pulse_found(4'($urandom_range(0, 15)), {$urandom(), $urandom(), $urandom(), $urandom()});
            end else if (r < 85) begin
                core_done = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
                tick();
            end else begin
                tick();
            end
        end
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/miner_csr_multi.md
Name: miner_csr_multi

Overview:
- Avalon-MM slave register block that fronts NUM_CORES parallel SHA-256 double-hash miner cores.
- Holds the 256-bit target and the 608-bit block-header prefix, and partitions the 32-bit nonce space evenly across the cores.
- Sequences start, abort and completion, and captures the first winning nonce together with the index of the core that found it.
- Successor to the single-core top-level register interface: same address map for words 0–29, plus multi-core partitioning, abort, exhaustion detection and a winner-index register.

Parameters:
- NUM_CORES, 4, number of miner cores; power of 2, range 1..16.
- CORE_IDX_W, $clog2(NUM_CORES) (minimum 1), width of the winning-core index.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- slaveAddr  in  5  word address
- slaveWriteData  in  32  write data
- slaveWrite  in  1  write strobe, qualified by slaveChipSelect
- slaveRead  in  1  read strobe, qualified by slaveChipSelect
- slaveChipSelect  in  1  slave select
- slaveReadData  out  32  registered read data
- target  out  256  target value to all cores
- message  out  608  header prefix to all cores
- core_start  out  NUM_CORES  one-cycle start pulse, one bit per core
- core_abort  out  1  one-cycle abort pulse to all cores
- core_start_nonce  out  NUM_CORES*32  first nonce per core
- core_found  in  NUM_CORES  core i found a hash below target (1-cycle pulse)
- core_nonce  in  NUM_CORES*32  winning nonce per core, valid with core_found
- core_done  in  NUM_CORES  core i exhausted its range (level, cleared by core_start)
- irq  out  1  high while status is FOUND or EXHAUSTED

Behaviour:
- Reset values: all registers 0, slaveReadData 0, core_start 0, core_abort 0, irq 0, FSM in IDLE.
- Address map:
  - 0 status (RO): 0 = IDLE, 1 = RUNNING, 3 = FOUND, 4 = EXHAUSTED.
  - 1 control (WO): bit0 load target, bit1 start, bit2 abort.
  - 2..9 target words; 2 = bits[31:0], 9 = bits[255:224].
  - 10 result nonce (RO).
  - 11..29 message words; 29 = bits[607:576], 11 = bits[31:0].
  - 30 winning core index (RO, zero-extended).
  - 31 NUM_CORES (RO).
- Writes: take effect on the clk edge when slaveChipSelect & slaveWrite. Writes to RO addresses are ignored. Target and message staging registers are writable in any state.
- Shadowing: `target` and `message` outputs come from shadow copies.
  - Control bit0 copies the target staging register into its shadow.
  - Control bit1 copies the message staging register into its shadow.
  - Control bits are pulse-only: a write of 0 has no effect and nothing is stored.
- Reads: slaveReadData is updated one cycle after slaveChipSelect & slaveRead; otherwise it holds its value. Reading addresses 2..29 returns the staging values.
- Nonce partition: core_start_nonce[i] = i << (32 - log2(NUM_CORES)). With NUM_CORES = 1 this is 0.
- FSM:
  - IDLE / FOUND / EXHAUSTED, on start → RUNNING. core_start is pulsed to all cores the cycle after the write; the result nonce and winner index are cleared.
  - RUNNING, on start → restart: core_abort pulses, then core_start pulses on the next cycle.
  - RUNNING, on any core_found → FOUND. Capture the lowest-index core with core_found set, and that core's nonce. core_abort pulses the next cycle.
  - RUNNING, when all core_done bits are high and no core_found is set that cycle → EXHAUSTED.
  - Any state, on abort → IDLE, with a core_abort pulse. Abort beats start in the same write.
  - core_found and the all-done condition in the same cycle → FOUND.
- Outside RUNNING, core_found is ignored (no overwrite of the captured result).
- Reset mid-run: all state clears immediately. No core_abort pulse is issued; the cores reset on the same n_rst.

Decomposition:
- Shared package miner_pkg holds:
  - address localparams ADDR_STATUS = 0, ADDR_CTRL = 1, ADDR_TGT_LO = 2, ADDR_NONCE = 10, ADDR_MSG_LO = 11, ADDR_WINNER = 30, ADDR_NCORES = 31;
  - status enum {IDLE = 0, RUNNING = 1, FOUND = 3, EXHAUSTED = 4};
  - control bit positions.
- One sub-module, miner_found_arbiter: a combinational lowest-index priority encoder plus nonce mux, NUM_CORES-parameterised.

Test Plan:
1. Reset, then read addr 31 → 4; read addr 0 → 0; irq = 0; all core outputs 0.
2. Write target 256'h1000…0 to addr 9..2, then ctrl = 1 → target output equals the value. Write addr 9 = 0xFFFFFFFF without ctrl → target unchanged, while readback of addr 9 returns 0xFFFFFFFF.
3. Load message, ctrl = 2 → core_start = 4'b1111 for 1 cycle; start nonces are 0x00000000, 0x40000000, 0x80000000, 0xC0000000; status reads 1.
4. In RUNNING, pulse core_found = 4'b0110 with core_nonce[1] = 0x4000002A and core_nonce[2] = 0x80000011 → status 3, addr 10 = 0x4000002A, addr 30 = 1, core_abort pulses once, irq = 1. A later core_found[0] → result unchanged.
5. Start, then raise core_done = 4'b1111 → status 4, irq = 1. Ctrl = 2 again → status 1, result reads 0.
6. In RUNNING, write ctrl = 6 → core_abort pulses, no core_start, status 0. Assert n_rst low mid-run → all outputs 0 asynchronously.
